rr_arb_4_1: RTL and testbench
=============================

RR_ARB_4_1 -- requirements
Module: rr_arb_4_1

Interface
REQ-001 Parameter WIDTH, default 4, payload width in bits of every input and output data port.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  4  per-requester valid; bit i belongs to requester i.
REQ-005 in_data0..in_data3  input  WIDTH each  per-requester payload, sampled only when that requester is granted.
REQ-006 in_ready  output  4  per-requester ready; a transfer on requester i occurs when in_valid[i] and in_ready[i] are both 1 at a rising edge.
REQ-007 out_valid  output  1  registered output payload is valid.
REQ-008 out_data  output  WIDTH  registered payload of the granted requester.
REQ-009 out_sel  output  2  registered index (0..3) of the requester that supplied out_data; this is the 4:1 mux select.
REQ-010 out_ready  input  1  downstream accepts; an output transfer occurs when out_valid and out_ready are both 1 at a rising edge.

Function
REQ-011 Internal state: output register (out_valid, out_data, out_sel) plus 2-bit priority pointer ptr.
REQ-012 load = (~out_valid | out_ready), evaluated combinationally each cycle.
REQ-013 Grant search: the first requester with in_valid set, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); at most one grant per cycle.
REQ-014 in_ready[i] = 1 only when load = 1 and requester i is the granted one; all other in_ready bits are 0.
REQ-015 Combinational paths in_valid->in_ready and out_ready->in_ready are permitted; no path exists from any input to out_valid, out_data or out_sel.
REQ-016 On a rising edge with load = 1 and grant g: out_valid <= 1, out_data <= in_data[g], out_sel <= g, ptr <= (g+1) mod 4.
REQ-017 On a rising edge with load = 1 and no in_valid bit set: out_valid <= 0; out_data, out_sel and ptr hold.
REQ-018 On a rising edge with load = 0 (out_valid = 1, out_ready = 0): out_valid, out_data, out_sel and ptr hold; in_ready = 0.
REQ-019 Latency: an accepted input appears at the outputs exactly 1 cycle after acceptance.
REQ-020 Throughput: with out_ready held at 1, one transfer per cycle with no bubbles.
REQ-021 Fairness: with all four requesters continuously valid and out_ready = 1, grants rotate 0,1,2,3,0,... and no requester waits more than 3 grants.
REQ-022 ptr wrap-around: a grant to 3 sets ptr to 0.
REQ-023 A requester that drops in_valid before being granted loses no state and is not granted.
REQ-024 in_data of non-granted requesters never affects outputs.

Reset
REQ-025 While rst_n = 0, independent of clk: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, in_ready = 4'b0000.
REQ-026 Reset asserted mid-transfer discards the held output payload; no output transfer is reported after assertion.
REQ-027 The first rising edge with rst_n = 1 behaves per REQ-016/017 with ptr = 0, giving requester 0 first priority.

Verification
REQ-028 After reset, in_valid = 4'b1111, in_data0..3 = 4'hA, 4'hB, 4'hC, 4'hD, out_ready = 1 for 5 cycles -> out_sel sequence 0,1,2,3,0 and out_data A,B,C,D,A, each 1 cycle after acceptance.
REQ-029 Output stall: out_valid = 1 with out_data = 4'h5, out_ready = 0 for 3 cycles while in_valid = 4'b0110 -> out_data stays 4'h5, in_ready = 4'b0000 throughout; out_ready = 1 -> requester 1 is granted in the same cycle.
REQ-030 Sparse request: ptr = 2, in_valid = 4'b0001 -> requester 0 granted (wrap-around), ptr becomes 1; then in_valid = 4'b0000 with out_ready = 1 -> out_valid = 0 on the next edge, ptr stays 1.
REQ-031 Back-to-back single requester: in_valid = 4'b1000 for 4 cycles, out_ready = 1 -> four consecutive transfers, out_sel = 3 each cycle, ptr = 0 after each grant.
REQ-032 Asynchronous reset: drive rst_n low mid-cycle while out_valid = 1 -> out_valid, out_sel, out_data and in_ready go to 0 immediately, without waiting for a clock edge; after release with in_valid = 4'b1010 -> requester 1 is granted first.

Source files
------------

// File: rtl/rr_arb_4_1.sv
// Purpose: 4:1 round-robin arbiter with a registered output stage (data, select, valid).
// Latency: 1 cycle from input acceptance to out_valid/out_data/out_sel.
// Backpressure: out_ready=0 with out_valid=1 holds the output register and drops all in_ready bits.
module rr_arb_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  // Output register and priority pointer (current / next).
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_sel_q,   out_sel_d;
  logic [1:0]       ptr_q,       ptr_d;

  // Arbitration results for this cycle.
  logic             load;
  logic             gnt_vld;
  logic [1:0]       gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  // The output register can take a new word when empty or being drained this cycle.
  assign load = ~out_valid_q | out_ready;

  // Rotating priority search starting at ptr; first valid requester wins.
  always_comb begin
    logic [1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_vld && in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Payload mux driven only by the winning index, so losers' data never reaches the output.
  always_comb begin
    gnt_data = in_data0;
    case (gnt_idx)
      2'd0:    gnt_data = in_data0;
      2'd1:    gnt_data = in_data1;
      2'd2:    gnt_data = in_data2;
      default: gnt_data = in_data3;
    endcase
  end

  // Handshake back to the winner only; gated by rst_n so reset clears it without a clock.
  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && load && gnt_vld) begin
      in_ready = 4'b0001 << gnt_idx;
    end
  end

  // Next-state: capture the winner, go empty on an idle load, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gnt_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = gnt_data;
        out_sel_d   = gnt_idx;
        ptr_d       = gnt_idx + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; asynchronous reset discards any held payload and restarts priority at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      ptr_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_4_1.sv
module tb_rr_arb_4_1;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;

  int checks;
  int failures;

  rr_arb_4_1 #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data0 = 4'h1; in_data1 = 4'h2; in_data2 = 4'h3; in_data3 = 4'h4;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 4'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (out_sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", out_sel); end
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_hold_valid got=%b exp=0", out_valid); end
    checks++; if (dut.ptr_q !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr_q); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // All four valid: grants rotate 0,1,2,3,0 with data A,B,C,D,A.
  task automatic test_rotation();
    logic [3:0] exp_data [5];
    logic [1:0] exp_sel  [5];
    exp_data[0] = 4'hA; exp_data[1] = 4'hB; exp_data[2] = 4'hC; exp_data[3] = 4'hD; exp_data[4] = 4'hA;
    exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2; exp_sel[3] = 2'd3; exp_sel[4] = 2'd0;
    in_valid = 4'b1111; out_ready = 1'b1;
    in_data0 = 4'hA; in_data1 = 4'hB; in_data2 = 4'hC; in_data3 = 4'hD;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== (4'b0001 << exp_sel[i])) begin failures++; $display("FAIL rot_in_ready[%0d] got=%b exp=%b", i, in_ready, 4'b0001 << exp_sel[i]); end
      checks++; if (i == 0 && out_valid !== 1'b0) begin failures++; $display("FAIL rot_pre_valid got=%b exp=0", out_valid); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rot_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_sel !== exp_sel[i]) begin failures++; $display("FAIL rot_sel[%0d] got=%0d exp=%0d", i, out_sel, exp_sel[i]); end
      checks++; if (out_data !== exp_data[i]) begin failures++; $display("FAIL rot_data[%0d] got=%h exp=%h", i, out_data, exp_data[i]); end
    end
    checks++; if (dut.ptr_q !== 2'd1) begin failures++; $display("FAIL rot_ptr got=%0d exp=1", dut.ptr_q); end
  endtask

  // Hold 5 under backpressure with 0110 pending; release grants requester 1.
  task automatic test_stall();
    in_valid = 4'b0001; in_data0 = 4'h5; in_data1 = 4'h7; in_data2 = 4'h9; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_data !== 4'h5 || out_valid !== 1'b1) begin failures++; $display("FAIL stall_setup got=%b/%h exp=1/5", out_valid, out_data); end
    out_ready = 1'b0; in_valid = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0000", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_data !== 4'h5 || out_valid !== 1'b1 || out_sel !== 2'd0) begin
        failures++; $display("FAIL stall_hold[%0d] got=%b/%h/%0d exp=1/5/0", i, out_valid, out_data, out_sel); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL stall_release_ready got=%b exp=0010", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_sel !== 2'd1 || out_data !== 4'h7) begin failures++; $display("FAIL stall_release_out got=%0d/%h exp=1/7", out_sel, out_data); end
    checks++; if (dut.ptr_q !== 2'd2) begin failures++; $display("FAIL stall_ptr got=%0d exp=2", dut.ptr_q); end
  endtask

  // ptr=2 with only requester 0 valid wraps to 0; then idle drops out_valid and ptr holds.
  task automatic test_sparse();
    in_valid = 4'b0001; in_data0 = 4'h3; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL sparse_ready got=%b exp=0001", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_sel !== 2'd0 || out_data !== 4'h3 || out_valid !== 1'b1) begin
      failures++; $display("FAIL sparse_grant got=%b/%0d/%h exp=1/0/3", out_valid, out_sel, out_data); end
    checks++; if (dut.ptr_q !== 2'd1) begin failures++; $display("FAIL sparse_ptr got=%0d exp=1", dut.ptr_q); end
    in_valid = 4'b0000;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL idle_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
    checks++; if (dut.ptr_q !== 2'd1 || out_sel !== 2'd0 || out_data !== 4'h3) begin
      failures++; $display("FAIL idle_hold got=%0d/%0d/%h exp=1/0/3", dut.ptr_q, out_sel, out_data); end
  endtask

  // Single requester 3 every cycle; other payloads churn and must not leak.
  task automatic test_back_to_back();
    in_valid = 4'b1000; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data3 = 4'(8 + i);
      in_data0 = 4'(i); in_data1 = 4'(15 - i); in_data2 = 4'(i + 2);
      #1;
      checks++; if (in_ready !== 4'b1000) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1000", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 4'(8 + i)) begin
        failures++; $display("FAIL b2b_out[%0d] got=%b/%0d/%h exp=1/3/%h", i, out_valid, out_sel, out_data, 4'(8 + i)); end
      checks++; if (dut.ptr_q !== 2'd0) begin failures++; $display("FAIL b2b_ptr[%0d] got=%0d exp=0", i, dut.ptr_q); end
    end
  endtask

  // Reset mid-cycle clears outputs immediately; after release requester 1 wins from 1010.
  task automatic test_async_reset();
    in_valid = 4'b1010; in_data1 = 4'hE; in_data3 = 4'h6; out_ready = 1'b1;
    #2;
    checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL areset_pre_ready got=%b exp=0010", in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 4'h0) begin
      failures++; $display("FAIL areset_out got=%b/%0d/%h exp=0/0/0", out_valid, out_sel, out_data); end
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL areset_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || dut.ptr_q !== 2'd0) begin failures++; $display("FAIL areset_hold got=%b/%0d exp=0/0", out_valid, dut.ptr_q); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL areset_release_ready got=%b exp=0010", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 4'hE) begin
      failures++; $display("FAIL areset_first_grant got=%b/%0d/%h exp=1/1/e", out_valid, out_sel, out_data); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_rotation();
    test_stall();
    test_sparse();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
